// File: rtl/sklansky_pipe_addsub_if.sv
// Operand/result stream for sklansky_pipe_addsub: valid/ready beats in, valid/ready results out.
// No storage here; timing and backpressure live in the block that uses the slave modport.
interface sklansky_pipe_addsub_if #(
    parameter int N = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/sklansky_pipe_addsub.sv
// Pipelined Sklansky prefix adder/subtractor; ovf/zero flags built only with SKLANSKY_FLAGS_EN.
// Latency 1 + ceil($clog2(N)/REG_EVERY) cycles, one beat per cycle.
// Backpressure: a held output freezes every stage; in_ready = ~(out_valid & ~out_ready).
module sklansky_pipe_addsub #(
    parameter int N         = 64,
    parameter int REG_EVERY = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sklansky_pipe_addsub_if.slave  io
);
    localparam int LOG = $clog2(N);

    logic stall;
    logic en;

    assign stall       = io.out_valid & ~io.out_ready;
    assign en          = ~stall;
    assign io.in_ready = en;

    // Stage 0: operands with subtraction already folded into b and the carry.
    logic         v0;
    logic [N-1:0] a0;
    logic [N-1:0] b0;
    logic         c0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0 <= 1'b0;
            a0 <= '0;
            b0 <= '0;
            c0 <= 1'b0;
        end else if (en) begin
            v0 <= io.in_valid;
            if (io.in_valid) begin
                a0 <= io.a;
                b0 <= io.sub ? ~io.b : io.b;
                c0 <= io.cin ^ io.sub;
            end
        end
    end

    for (genvar s = 0; s < LOG; s++) begin : lvl
        localparam int H      = 1 << s;
        localparam bit IS_REG = (s < LOG - 1) && (((s + 1) % REG_EVERY) == 0);

        logic [N-1:0] g_i, p_i, x_i, g_o, p_o, g_q, p_q, x_q;
        logic         c_i, v_i, c_q, v_q;
`ifdef SKLANSKY_FLAGS_EN
        logic         am_i, bm_i, am_q, bm_q;
`endif

        if (s == 0) begin : src
            assign p_i = a0 ^ b0;
            assign x_i = a0 ^ b0;
            assign g_i = (a0 & b0) | {{(N-1){1'b0}}, p_i[0] & c0};
            assign c_i = c0;
            assign v_i = v0;
`ifdef SKLANSKY_FLAGS_EN
            assign am_i = a0[N-1];
            assign bm_i = b0[N-1];
`endif
        end else begin : src
            assign g_i = lvl[s-1].g_q;
            assign p_i = lvl[s-1].p_q;
            assign x_i = lvl[s-1].x_q;
            assign c_i = lvl[s-1].c_q;
            assign v_i = lvl[s-1].v_q;
`ifdef SKLANSKY_FLAGS_EN
            assign am_i = lvl[s-1].am_q;
            assign bm_i = lvl[s-1].bm_q;
`endif
        end

        // Bits with index bit s set absorb the top bit of the block just below them.
        always_comb begin
            g_o = g_i;
            p_o = p_i;
            for (int i = 0; i < N; i++) begin
                if (((i >> s) & 1) == 1) begin
                    g_o[i] = g_i[i] | (p_i[i] & g_i[(i | (H - 1)) - H]);
                    p_o[i] = p_i[i] & p_i[(i | (H - 1)) - H];
                end
            end
        end

        if (IS_REG) begin : stg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= 1'b0;
                    g_q <= '0;
                    p_q <= '0;
                    x_q <= '0;
                    c_q <= 1'b0;
                end else if (en) begin
                    v_q <= v_i;
                    g_q <= g_o;
                    p_q <= p_o;
                    x_q <= x_i;
                    c_q <= c_i;
                end
            end
`ifdef SKLANSKY_FLAGS_EN
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    am_q <= 1'b0;
                    bm_q <= 1'b0;
                end else if (en) begin
                    am_q <= am_i;
                    bm_q <= bm_i;
                end
            end
`endif
        end else begin : thru
            assign v_q = v_i;
            assign g_q = g_o;
            assign p_q = p_o;
            assign x_q = x_i;
            assign c_q = c_i;
`ifdef SKLANSKY_FLAGS_EN
            assign am_q = am_i;
            assign bm_q = bm_i;
`endif
        end
    end

    logic [N-1:0] fin_g;
    logic [N-1:0] fin_x;
    logic [N-1:0] sum_nx;
    logic         fin_c;
    logic         fin_v;
    logic         unused_p;

    assign fin_g    = lvl[LOG-1].g_q;
    assign fin_x    = lvl[LOG-1].x_q;
    assign fin_c    = lvl[LOG-1].c_q;
    assign fin_v    = lvl[LOG-1].v_q;
    assign unused_p = ^lvl[LOG-1].p_q;
    assign sum_nx   = fin_x ^ {fin_g[N-2:0], fin_c};

    logic         out_valid_q;
    logic [N-1:0] sum_q;
    logic         cout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
        end else if (en) begin
            out_valid_q <= fin_v;
            sum_q       <= sum_nx;
            cout_q      <= fin_g[N-1];
        end
    end

    assign io.out_valid = out_valid_q;
    assign io.sum       = sum_q;
    assign io.cout      = cout_q;

`ifdef SKLANSKY_FLAGS_EN
    logic ovf_q;
    logic zero_q;

    // Flags are qualified by the stage valid so they never assert on a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (en) begin
            ovf_q  <= fin_v & (lvl[LOG-1].am_q == lvl[LOG-1].bm_q) & (sum_nx[N-1] != lvl[LOG-1].am_q);
            zero_q <= fin_v & (sum_nx == '0);
        end
    end

    assign io.ovf  = ovf_q;
    assign io.zero = zero_q;
`else
    assign io.ovf  = 1'b0;
    assign io.zero = 1'b0;
`endif
endmodule

// File: tb/tb_sklansky_pipe_addsub.sv
// Directed bench: a 64-bit (REG_EVERY=1) and an 8-bit (REG_EVERY=2) instance sharing clock and reset.
module tb_sklansky_pipe_addsub;
    logic clk;
    logic rst_n;

    int total = 0;
    int bad   = 0;

`ifdef SKLANSKY_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    sklansky_pipe_addsub_if #(.N(64)) if64 ();
    sklansky_pipe_addsub_if #(.N(8))  if8  ();

    sklansky_pipe_addsub #(.N(64), .REG_EVERY(1)) dut64 (.clk(clk), .rst_n(rst_n), .io(if64));
    sklansky_pipe_addsub #(.N(8),  .REG_EVERY(2)) dut8  (.clk(clk), .rst_n(rst_n), .io(if8));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {a, b, cin, sub, cout, sum}
    localparam logic [26:0] VEC [8] = '{
        {8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 8'h46},
        {8'hF0, 8'h20, 1'b0, 1'b0, 1'b1, 8'h10},
        {8'h50, 8'h30, 1'b0, 1'b1, 1'b1, 8'h20},
        {8'h30, 8'h50, 1'b0, 1'b1, 1'b0, 8'hE0},
        {8'h01, 8'h01, 1'b1, 1'b0, 1'b0, 8'h03},
        {8'hAA, 8'h55, 1'b0, 1'b0, 1'b0, 8'hFF},
        {8'hAA, 8'h55, 1'b1, 1'b0, 1'b1, 8'h00},
        {8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00}
    };

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run64(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic sub, input logic [63:0] esum,
                         input logic ecout, input logic eovf, input logic ezero);
        int lat;
        @(posedge clk); #1;
        if64.in_valid = 1'b1; if64.a = a; if64.b = b; if64.cin = cin; if64.sub = sub;
        lat = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (c == 1) if64.in_valid = 1'b0;
            if (if64.out_valid) begin
                lat = c;
                break;
            end
        end
        chk({tag, "_lat"},  64'(lat), 64'd7);
        chk({tag, "_sum"},  if64.sum, esum);
        chk({tag, "_cout"}, 64'(if64.cout), 64'(ecout));
        chk({tag, "_ovf"},  64'(if64.ovf),  64'(eovf & FLAGS));
        chk({tag, "_zero"}, 64'(if64.zero), 64'(ezero & FLAGS));
    endtask

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub, input logic [7:0] esum,
                        input logic ecout, input logic eovf, input logic ezero);
        int lat;
        @(posedge clk); #1;
        if8.in_valid = 1'b1; if8.a = a; if8.b = b; if8.cin = cin; if8.sub = sub;
        lat = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (c == 1) if8.in_valid = 1'b0;
            if (if8.out_valid) begin
                lat = c;
                break;
            end
        end
        chk({tag, "_lat"},  64'(lat), 64'd3);
        chk({tag, "_sum"},  64'(if8.sum),  64'(esum));
        chk({tag, "_cout"}, 64'(if8.cout), 64'(ecout));
        chk({tag, "_ovf"},  64'(if8.ovf),  64'(eovf & FLAGS));
        chk({tag, "_zero"}, 64'(if8.zero), 64'(ezero & FLAGS));
    endtask

    initial begin
        logic [26:0] v;
        logic        exp_rdy;
        int          idx;
        int          got;

        rst_n = 1'b0;
        if64.in_valid = 1'b0; if64.a = '0; if64.b = '0; if64.cin = 1'b0; if64.sub = 1'b0; if64.out_ready = 1'b1;
        if8.in_valid  = 1'b0; if8.a  = '0; if8.b  = '0; if8.cin  = 1'b0; if8.sub  = 1'b0; if8.out_ready  = 1'b1;

        #3;
        chk("rst64_valid", 64'(if64.out_valid), 64'd0);
        chk("rst64_sum",   if64.sum, 64'd0);
        chk("rst64_cout",  64'(if64.cout), 64'd0);
        chk("rst64_ovf",   64'(if64.ovf), 64'd0);
        chk("rst64_zero",  64'(if64.zero), 64'd0);
        chk("rst64_rdy",   64'(if64.in_ready), 64'd1);
        chk("rst8_valid",  64'(if8.out_valid), 64'd0);
        chk("rst8_sum",    64'(if8.sum), 64'd0);
        chk("rst8_rdy",    64'(if8.in_ready), 64'd1);

        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        run64("w64_allones_p1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
        run64("w64_alt_cin",    64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
        run64("w64_0_minus_1",  64'd0, 64'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
        run64("w64_min_minus1", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
        run64("w64_mixed",      64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 64'h1234_5678_9ABC_DF00, 1'b0, 1'b0, 1'b0);

        run8("w8_5_minus_7",  8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        run8("w8_7f_plus_1",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        run8("w8_ff_cin",     8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        run8("w8_borrow_in",  8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0, 1'b0);
        run8("w8_80_minus_1", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);

        // Streaming with out_ready low every third cycle.
        idx = 0;
        got = 0;
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            @(posedge clk); #1;
            if8.out_ready = (cyc % 3) != 2;
            if (idx < 8) begin
                v = VEC[idx];
                if8.a = v[26:19]; if8.b = v[18:11]; if8.cin = v[10]; if8.sub = v[9];
                if8.in_valid = 1'b1;
            end else begin
                if8.in_valid = 1'b0;
            end
            #1;
            exp_rdy = ~(if8.out_valid & ~if8.out_ready);
            chk("stream_in_ready", 64'(if8.in_ready), 64'(exp_rdy));
            if (if8.out_valid && if8.out_ready) begin
                v = VEC[got];
                chk("stream_result", 64'({if8.cout, if8.sum}), 64'(v[8:0]));
                got++;
            end
            if (if8.in_valid && if8.in_ready) idx++;
        end
        chk("stream_count", 64'(got), 64'd8);
        @(posedge clk); #1;
        if8.in_valid  = 1'b0;
        if8.out_ready = 1'b1;

        // Fill the 64-bit pipeline against a blocked output, then drain.
        @(posedge clk); #1;
        if64.out_ready = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 40 && idx < 7; cyc++) begin
            @(posedge clk); #1;
            if64.in_valid = 1'b1; if64.a = 64'(idx + 1); if64.b = 64'd100; if64.cin = 1'b0; if64.sub = 1'b0;
            #1;
            if (if64.in_ready) idx++;
        end
        @(posedge clk); #1;
        if64.in_valid = 1'b0;
        chk("fill_accepted", 64'(idx), 64'd7);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            chk("stall_valid", 64'(if64.out_valid), 64'd1);
            chk("stall_sum",   if64.sum, 64'd101);
            chk("stall_rdy",   64'(if64.in_ready), 64'd0);
        end
        @(posedge clk); #1;
        if64.out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            chk("drain_valid", 64'(if64.out_valid), 64'd1);
            chk("drain_sum",   if64.sum, 64'(101 + k));
            @(posedge clk); #1;
        end
        chk("drain_empty", 64'(if64.out_valid), 64'd0);

        // Reset with three beats in flight in the 8-bit pipeline.
        @(posedge clk); #1;
        if8.in_valid = 1'b1; if8.a = 8'h11; if8.b = 8'h22; if8.cin = 1'b0; if8.sub = 1'b0;
        @(posedge clk); #1;
        if8.a = 8'h33;
        @(posedge clk); #1;
        if8.a = 8'h44;
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
        chk("pre_rst_valid", 64'(if8.out_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(if8.out_valid), 64'd0);
        chk("midrst_sum",   64'(if8.sum), 64'd0);
        chk("midrst_cout",  64'(if8.cout), 64'd0);
        chk("midrst_rdy",   64'(if8.in_ready), 64'd1);
        chk("midrst_zero",  64'(if8.zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("post_rst_quiet", 64'(if8.out_valid), 64'd0);
        end
        run8("w8_after_rst", 8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
